// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// FSM states and small op-decode helpers.
package muldiv_unit_pkg;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } mdu_state_e;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  // MULT and DIV are the signed flavours (op[0] clear).
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Start/busy/done handshake, MTHI/MTLO port and HI/LO result bus of the
// multiply/divide unit.
interface muldiv_unit_if #(parameter int unsigned WIDTH = 32);

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mt_hi;
  logic             mt_lo;
  logic [WIDTH-1:0] mt_data;
  logic             busy;
  logic             done;
  logic             dz;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, mt_hi, mt_lo, mt_data,
    input  busy, done, dz, hi, lo
  );

  modport slave (
    input  start, op, a, b, mt_hi, mt_lo, mt_data,
    output busy, done, dz, hi, lo
  );

endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration on {acc, q}: shift-add for multiply (LSB first),
// restoring shift-subtract for divide (MSB first).
module muldiv_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] acc_n,
  output logic [WIDTH-1:0] q_n
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem;
  logic [WIDTH:0] diff;

  always_comb begin
    sum  = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
    rem  = {acc, q[WIDTH-1]};
    diff = rem - {1'b0, m};
    if (div) begin
      // Top bit of diff set means the trial subtract borrowed: restore.
      if (!diff[WIDTH]) begin
        acc_n = diff[WIDTH-1:0];
        q_n   = {q[WIDTH-2:0], 1'b1};
      end else begin
        acc_n = rem[WIDTH-1:0];
        q_n   = {q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_n = sum[WIDTH:1];
      q_n   = {sum[0], q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers,
// MTHI/MTLO writes and a start/busy/done handshake for pipeline stalls.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input logic           clk,
  input logic           rst,
  muldiv_unit_if.slave  bus
);

  mdu_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc, q, m, a_org;
  logic             div_op, neg_q, neg_r, dz_r;
  logic [WIDTH-1:0] hi_r, lo_r;
  logic             busy_r, done_r, dz_o;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] acc_n, q_n;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] res_hi, res_lo;

  always_comb begin
    a_neg = op_is_signed(bus.op) & bus.a[WIDTH-1];
    b_neg = op_is_signed(bus.op) & bus.b[WIDTH-1];
    a_mag = a_neg ? -bus.a : bus.a;
    b_mag = b_neg ? -bus.b : bus.b;
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div   (div_op),
    .acc   (acc),
    .q     (q),
    .m     (m),
    .acc_n (acc_n),
    .q_n   (q_n)
  );

  // Sign fixup is applied to the last iteration's output so HI/LO and done
  // land on the same edge that enters DONE.
  always_comb begin
    prod   = {acc_n, q_n};
    res_hi = '0;
    res_lo = '0;
    if (!div_op) begin
      if (neg_q) prod = -prod;
      {res_hi, res_lo} = prod;
    end else if (dz_r) begin
      res_lo = '1;
      res_hi = a_org;
    end else begin
      res_lo = neg_q ? -q_n : q_n;
      res_hi = neg_r ? -acc_n : acc_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      acc    <= '0;
      q      <= '0;
      m      <= '0;
      a_org  <= '0;
      div_op <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz_r   <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      dz_o   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.mt_hi) hi_r <= bus.mt_data;
          if (bus.mt_lo) lo_r <= bus.mt_data;
          if (bus.start) begin
            acc    <= '0;
            q      <= a_mag;
            m      <= b_mag;
            a_org  <= bus.a;
            div_op <= op_is_div(bus.op);
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            dz_r   <= op_is_div(bus.op) & (bus.b == '0);
            cnt    <= CNT_W'(WIDTH);
            busy_r <= 1'b1;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          acc <= acc_n;
          q   <= q_n;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            hi_r   <= res_hi;
            lo_r   <= res_lo;
            done_r <= 1'b1;
            dz_o   <= dz_r;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          done_r <= 1'b0;
          dz_o   <= 1'b0;
          busy_r <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.dz   = dz_o;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;

endmodule
